uart_rx_ctrl: RTL

Controller that sequences one `uartRX` receiver instance: it owns the receiver's `en` line, captures each completed byte into a small show-ahead FIFO with a valid/ready output, and recovers automatically from framing errors. It sits between `uartRX` and the byte consumer, and keeps saturating error and overflow counters for status readback.

---
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequencer for one uartRX receiver: owns its enable, buffers bytes in a show-ahead FIFO,
// auto-recovers from framing errors. Optional idle timeout under UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_en,
  output logic                          rx_en,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          rx_busy,
  input  logic                          rx_err,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    err_count,
  output logic [7:0]                    ovf_count,
  output logic [1:0]                    state,
  output logic                          timeout
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {S_OFF = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_RECOVER = 2'd3} state_e;

  state_e         state_q, state_d;
  logic [RCW-1:0] rec_q, rec_d;
  logic           rx_en_q, rx_en_d;
  logic [7:0]     err_q, err_d, ovf_q, ovf_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d, remain;
  logic [7:0]     head_q, head_d;
  logic           valid_q, valid_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic in_run, push_req, push, pop, full;

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    err_d    = err_q;
    in_run   = (state_q == S_RUN);
    push_req = in_run & rx_done & ~rx_err;
    case (state_q)
      S_OFF:   if (ctrl_en) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN: begin
        if (rx_err) begin
          state_d = S_RECOVER;
          rec_d   = RCW'(RECOVER_CYCLES);
        end
      end
      S_RECOVER: begin
        rec_d = rec_q - 1'b1;
        if (rec_q <= RCW'(1)) state_d = S_ARM;
      end
      default: state_d = S_OFF;
    endcase
    if (!ctrl_en) state_d = S_OFF;
    if (in_run && rx_err && err_q != 8'hFF) err_d = err_q + 8'd1;
    rx_en_d = (state_d == S_ARM) || (state_d == S_RUN);
  end

  // Pop frees a slot the same cycle, so a full FIFO with a pop still accepts the push.
  always_comb begin
    pop    = valid_q & m_ready;
    full   = (cnt_q == CW'(FIFO_DEPTH));
    push   = push_req & (~full | pop);
    ovf_d  = ovf_q;
    if (push_req && full && !pop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    remain = cnt_q - CW'(pop);
    head_d = head_q;
    if (remain != '0)  head_d = mem_q[rd_d];
    else if (push)     head_d = rx_data;
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      rec_q   <= '0;
      rx_en_q <= 1'b0;
      err_q   <= '0;
      ovf_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      rx_en_q <= rx_en_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rx_data;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          armed_q, armed_d, to_q, to_d;

  // Idle count only advances once a byte has arrived since the last pulse.
  always_comb begin
    idle_d  = idle_q;
    armed_d = armed_q;
    to_d    = 1'b0;
    if (push_req) armed_d = 1'b1;
    if (!in_run || rx_done || rx_busy) begin
      idle_d = '0;
    end else if (armed_q) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_d    = 1'b1;
        idle_d  = '0;
        armed_d = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q  <= '0;
      armed_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      armed_q <= armed_d;
      to_q    <= to_d;
    end
  end

  assign timeout = to_q;
`else
  logic unused_busy;
  assign unused_busy = rx_busy ^ (TIMEOUT_CYCLES == 0);
  assign timeout     = 1'b0;
`endif

  assign rx_en      = rx_en_q;
  assign m_data     = head_q;
  assign m_valid    = valid_q;
  assign fifo_count = cnt_q;
  assign err_count  = err_q;
  assign ovf_count  = ovf_q;
  assign state      = state_q;

endmodule
